// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared widths, digit constants and FSM encoding for the BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  localparam int BIN_W_DEF = 8;
  localparam int NDIG_DEF  = 3;
  localparam int DIG_W     = 4;

  localparam logic [DIG_W-1:0] MAX_DIG  = 4'd9;
  localparam logic [DIG_W-1:0] CORR_TH  = 4'd8;
  localparam logic [DIG_W-1:0] CORR_AMT = 4'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle: three BCD digits with a START strobe in, binary result with DONE/BUSY/ERR out.
interface bcd_to_bin_seq_if
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
);
  logic             start;
  logic [DIG_W-1:0] h;
  logic [DIG_W-1:0] t;
  logic [DIG_W-1:0] o;
  logic [BIN_W-1:0] bin;
  logic             done;
  logic             busy;
  logic             err;

  modport master (output start, h, t, o, input bin, done, busy, err);
  modport slave  (input start, h, t, o, output bin, done, busy, err);
endinterface

// File: rtl/bcd_to_bin_seq_sub3_if_gte8.sv
// Single-nibble correction step of reverse double-dabble: subtract 3 when the nibble is 8 or more.
// Purely combinational, zero latency, no flow control.
module sub3_if_gte8
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [DIG_W-1:0] nib_i,
  output logic [DIG_W-1:0] nib_o
);

  assign nib_o = (nib_i >= CORR_TH) ? nib_i - CORR_AMT : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Three-digit BCD to binary converter, one shift/correct iteration per clock.
// Result and one-cycle DONE appear BIN_W cycles after START is taken; START is ignored while BUSY.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
)(
  input  logic             clk_i,
  input  logic             rst_n_i,
  bcd_to_bin_seq_if.slave  cvt
);

  localparam int NDIG  = NDIG_DEF;
  localparam int BCD_W = NDIG * DIG_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_corr;
  logic [BIN_W-1:0] sr_shift;
  logic             err_n;

  // The LSB of the BCD register migrates into the MSB of the binary register.
  assign bcd_shift = bcd_q >> 1;
  assign sr_shift  = {bcd_q[0], sr_q[BIN_W-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : g_corr
    sub3_if_gte8 u_corr (
      .nib_i (bcd_shift[g*DIG_W +: DIG_W]),
      .nib_o (bcd_corr[g*DIG_W +: DIG_W])
    );
  end

  // A residual left in the BCD register after the last shift means the value exceeded BIN_W bits.
  assign err_n = bad_q | (bcd_corr != '0);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cvt.start) begin
          bcd_d   = {cvt.h, cvt.t, cvt.o};
          sr_d    = '0;
          cnt_d   = '0;
          bad_d   = (cvt.h > MAX_DIG) | (cvt.t > MAX_DIG) | (cvt.o > MAX_DIG);
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_d = bcd_corr;
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bin_d   = err_n ? '0 : sr_shift;
          err_d   = err_n;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cvt.bin  = bin_q;
  assign cvt.err  = err_q;
  assign cvt.done = done_q;
  assign cvt.busy = (state_q == ST_CONV);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: hand-computed BCD/binary vectors, handshake timing and reset abort.
module tb_bcd_to_bin_seq;
  import bcd_to_bin_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bcd_to_bin_seq_if #(.BIN_W(8)) bus ();

  bcd_to_bin_seq #(.BIN_W(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cvt     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents digits with START; when sync is set it first aligns to a falling edge.
  // Returns #1 after the accepting edge with the inputs scrambled.
  task automatic drive_start(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input bit sync);
    if (sync) @(negedge clk);
    bus.start = 1'b1;
    bus.h = h;
    bus.t = t;
    bus.o = o;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.h = 4'hF;
    bus.t = 4'hF;
    bus.o = 4'hF;
  endtask

  // Waits the 8 iteration edges, checking BUSY/no-DONE on the way and the result at the end.
  task automatic wait_result(input logic [7:0] exp_bin, input logic exp_err, input string nm);
    bit bad_wait;
    bad_wait = (bus.busy !== 1'b1) || (bus.done !== 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c < 8 && ((bus.busy !== 1'b1) || (bus.done !== 1'b0))) bad_wait = 1'b1;
    end
    n_cmp++;
    if (bad_wait) begin
      n_err++;
      $display("FAIL %s busy_window: busy/done wrong before 8th edge (busy=%b done=%b now)", nm, bus.busy, bus.done);
    end
    n_cmp++;
    if ({bus.done, bus.busy, bus.err, bus.bin} !== {1'b1, 1'b0, exp_err, exp_bin}) begin
      n_err++;
      $display("FAIL %s result: got done=%b busy=%b err=%b bin=%h, want done=1 busy=0 err=%b bin=%h",
               nm, bus.done, bus.busy, bus.err, bus.bin, exp_err, exp_bin);
    end
  endtask

  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic [7:0] exp_bin, input logic exp_err, input string nm);
    drive_start(h, t, o, 1'b1);
    wait_result(exp_bin, exp_err, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.h = 4'h0;
    bus.t = 4'h0;
    bus.o = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.done, bus.busy, bus.err, bus.bin} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_values: got done=%b busy=%b err=%b bin=%h, want all 0",
               bus.done, bus.busy, bus.err, bus.bin);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_scale();
    run_conv(4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, "full_scale_255");
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.done, bus.bin} !== {1'b0, 8'hFF}) begin
      n_err++;
      $display("FAIL done_pulse_hold: got done=%b bin=%h, want done=0 bin=ff", bus.done, bus.bin);
    end
  endtask

  task automatic test_values();
    run_conv(4'd1, 4'd2, 4'd8, 8'h80, 1'b0, "value_128");
    run_conv(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, "value_0");
    run_conv(4'd0, 4'd9, 4'd9, 8'h63, 1'b0, "value_99");
  endtask

  task automatic test_overflow();
    run_conv(4'd2, 4'd5, 4'd6, 8'h00, 1'b1, "overflow_256");
    run_conv(4'd9, 4'd9, 4'd9, 8'h00, 1'b1, "overflow_999");
  endtask

  task automatic test_invalid_digit();
    run_conv(4'd0, 4'hA, 4'd3, 8'h00, 1'b1, "invalid_tens");
  endtask

  task automatic test_back_to_back();
    run_conv(4'd1, 4'd0, 4'd0, 8'h64, 1'b0, "b2b_first_100");
    drive_start(4'd0, 4'd4, 4'd2, 1'b0);
    wait_result(8'h2A, 1'b0, "b2b_second_42");
  endtask

  task automatic test_start_ignored();
    bit spurious;
    drive_start(4'd1, 4'd2, 4'd8, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 2 || c == 5);
      bus.h = 4'd0;
      bus.t = 4'd0;
      bus.o = 4'd7;
      if (c == 8) begin
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.done, bus.err, bus.bin} !== {1'b1, 1'b0, 8'h80}) begin
          n_err++;
          $display("FAIL start_during_conv_result: got done=%b err=%b bin=%h, want done=1 err=0 bin=80",
                   bus.done, bus.err, bus.bin);
        end
      end
    end
    spurious = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious) begin
      n_err++;
      $display("FAIL start_not_queued: got extra busy/done activity, want none (done=%b busy=%b)", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    drive_start(4'd2, 4'd5, 4'd5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.done, bus.busy, bus.err, bus.bin} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_mid_async: got done=%b busy=%b err=%b bin=%h, want all 0",
               bus.done, bus.busy, bus.err, bus.bin);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if ({bus.done, bus.busy, bus.err, bus.bin} !== 11'b0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got done=%b busy=%b err=%b bin=%h, want all 0 after release",
               bus.done, bus.busy, bus.err, bus.bin);
    end
    run_conv(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, "after_reset_42");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_scale();
    test_values();
    test_overflow();
    test_invalid_digit();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
